// File: rtl/harris_response.sv
// Harris corner-response pipeline: Sobel gradients, structure tensor, R = det - k*trace^2,
// threshold and border suppression, with each result tagged by its window's raster coordinates.
module harris_response #(
   parameter int                 IMG_WIDTH  = 480,
   parameter int                 IMG_HEIGHT = 480,
   parameter int                 K_NUM      = 5,
   parameter int                 K_SHIFT    = 7,
   parameter logic signed [51:0] THRESH     = 52'sd1_000_000_000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [0:5][0:5][7:0] window,
   input  logic                 window_valid,
   output logic                 corner_valid,
   output logic                 corner,
   output logic signed [51:0]   response,
   output logic [8:0]           corner_x,
   output logic [8:0]           corner_y,
   output logic                 frame_done
);

   localparam logic [8:0]         X_LAST   = 9'(IMG_WIDTH - 1);
   localparam logic [8:0]         X_BORDER = 9'(IMG_WIDTH - 6);
   localparam logic [8:0]         Y_LAST   = 9'(IMG_HEIGHT - 6);
   localparam logic signed [51:0] K_WIDE   = 52'(K_NUM);

   typedef struct packed {
      logic [8:0] x;
      logic [8:0] y;
      logic       border;
      logic       last;
   } tagT;

   typedef logic signed [10:0] gradT;

   logic [8:0]           xCount;
   logic [8:0]           yCount;
   logic [6:1]           validPipe;
   tagT                  tagPipe [1:6];

   logic [0:5][0:5][7:0] win1;
   gradT                 ixNext [1:4][1:4];
   gradT                 iyNext [1:4][1:4];
   gradT                 ix2    [1:4][1:4];
   gradT                 iy2    [1:4][1:4];
   logic signed [21:0]   sqXxNext [1:4][1:4];
   logic signed [21:0]   sqYyNext [1:4][1:4];
   logic signed [21:0]   sqXyNext [1:4][1:4];
   logic [20:0]          pxx3   [1:4][1:4];
   logic [20:0]          pyy3   [1:4][1:4];
   logic signed [21:0]   pxy3   [1:4][1:4];
   logic [24:0]          sumXx;
   logic [24:0]          sumYy;
   logic signed [25:0]   sumXy;
   logic [20:0]          sxx4;
   logic [20:0]          syy4;
   logic signed [21:0]   sxy4;
   logic signed [51:0]   sxxWide;
   logic signed [51:0]   syyWide;
   logic signed [51:0]   sxyWide;
   logic signed [51:0]   traceWide;
   logic signed [51:0]   detNext;
   logic signed [51:0]   t2Next;
   logic signed [51:0]   det5;
   logic signed [51:0]   t25;
   logic signed [51:0]   rNext;
   logic signed [51:0]   r6;

   // Raster position of the next incoming window; only real windows move it.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         xCount <= '0;
         yCount <= '0;
      end else if (window_valid) begin
         if (xCount == X_LAST) begin
            xCount <= '0;
            yCount <= (yCount == Y_LAST) ? '0 : yCount + 9'd1;
         end else begin
            xCount <= xCount + 9'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         validPipe <= '0;
      end else begin
         validPipe <= {validPipe[5:1], window_valid};
      end
   end

   // NOTE: datapath and tag registers carry no reset; the valid pipe alone decides what is real.
   always_ff @(posedge clk) begin
      win1       <= window;
      tagPipe[1] <= '{x:      xCount,
                      y:      yCount,
                      border: xCount > X_BORDER,
                      last:   (xCount == X_LAST) && (yCount == Y_LAST)};
      for (int i = 2; i <= 6; i++) begin
         tagPipe[i] <= tagPipe[i-1];
      end
   end

   function automatic gradT px(input logic [7:0] p);
      return gradT'({3'b000, p});
   endfunction

   // Sobel at the 16 interior positions; partial sums stay within +/-1020.
   always_comb begin
      for (int r = 1; r <= 4; r++) begin
         for (int c = 1; c <= 4; c++) begin
            ixNext[r][c] = px(win1[r-1][c+1]) + (px(win1[r][c+1]) <<< 1) + px(win1[r+1][c+1])
                         - px(win1[r-1][c-1]) - (px(win1[r][c-1]) <<< 1) - px(win1[r+1][c-1]);
            iyNext[r][c] = px(win1[r+1][c-1]) + (px(win1[r+1][c]) <<< 1) + px(win1[r+1][c+1])
                         - px(win1[r-1][c-1]) - (px(win1[r-1][c]) <<< 1) - px(win1[r-1][c+1]);
         end
      end
   end

   always_ff @(posedge clk) begin
      ix2 <= ixNext;
      iy2 <= iyNext;
   end

   always_comb begin
      for (int r = 1; r <= 4; r++) begin
         for (int c = 1; c <= 4; c++) begin
            sqXxNext[r][c] = 22'(ix2[r][c]) * 22'(ix2[r][c]);
            sqYyNext[r][c] = 22'(iy2[r][c]) * 22'(iy2[r][c]);
            sqXyNext[r][c] = 22'(ix2[r][c]) * 22'(iy2[r][c]);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int r = 1; r <= 4; r++) begin
         for (int c = 1; c <= 4; c++) begin
            pxx3[r][c] <= sqXxNext[r][c][20:0];
            pyy3[r][c] <= sqYyNext[r][c][20:0];
            pxy3[r][c] <= sqXyNext[r][c];
         end
      end
   end

   always_comb begin
      sumXx = '0;
      sumYy = '0;
      sumXy = '0;
      for (int r = 1; r <= 4; r++) begin
         for (int c = 1; c <= 4; c++) begin
            sumXx += 25'(pxx3[r][c]);
            sumYy += 25'(pyy3[r][c]);
            sumXy += 26'(pxy3[r][c]);
         end
      end
   end

   // Dropping the low four bits is the divide-by-16; on the signed sum it floors.
   always_ff @(posedge clk) begin
      sxx4 <= sumXx[24:4];
      syy4 <= sumYy[24:4];
      sxy4 <= sumXy[25:4];
   end

   always_comb begin
      sxxWide   = signed'(52'(sxx4));
      syyWide   = signed'(52'(syy4));
      sxyWide   = 52'(sxy4);
      traceWide = sxxWide + syyWide;
      detNext   = sxxWide * syyWide - sxyWide * sxyWide;
      t2Next    = traceWide * traceWide;
   end

   always_ff @(posedge clk) begin
      det5 <= detNext;
      t25  <= t2Next;
   end

   assign rNext = det5 - ((K_WIDE * t25) >>> K_SHIFT);

   always_ff @(posedge clk) begin
      r6 <= rNext;
   end

   // Data outputs only move on a real result so they hold through bubbles.
   always_ff @(posedge clk) begin
      if (reset) begin
         corner_valid <= 1'b0;
         frame_done   <= 1'b0;
         corner       <= 1'b0;
         response     <= '0;
         corner_x     <= '0;
         corner_y     <= '0;
      end else begin
         corner_valid <= validPipe[6];
         frame_done   <= validPipe[6] & tagPipe[6].last;
         if (validPipe[6]) begin
            response <= r6;
            corner   <= (r6 > THRESH) && !tagPipe[6].border;
            corner_x <= tagPipe[6].x;
            corner_y <= tagPipe[6].y;
         end
      end
   end

endmodule

// File: tb/tb_harris_response.sv
// Scoreboard bench for harris_response: a behavioural Harris model predicts every result,
// and a negedge monitor checks latency, values, coordinates, held outputs and frame_done.
module tb_harris_response;

   localparam int     W   = 480;
   localparam int     H   = 8;
   localparam int     KN  = 5;
   localparam int     KS  = 7;
   localparam longint THR = 1_000_000_000;

   typedef logic [0:5][0:5][7:0] winT;

   typedef struct {
      longint resp;
      bit     corner;
      int     x;
      int     y;
      bit     fd;
      int     due;
   } expT;

   logic                clk = 1'b0;
   logic                reset;
   winT                 window;
   logic                window_valid;
   logic                corner_valid;
   logic                corner;
   logic signed [51:0]  response;
   logic [8:0]          corner_x;
   logic [8:0]          corner_y;
   logic                frame_done;

   int     cycle = 0;
   int     nVectors = 0;
   int     nFails = 0;
   expT    sb[$];
   int     tbX = 0;
   int     tbY = 0;
   longint lastResp = 0;
   bit     lastCorner = 1'b0;
   int     lastX = 0;
   int     lastY = 0;
   int     fdCount = 0;
   int     fdX = -1;
   int     fdY = -1;
   int     dutX = -1;
   int     dutY = -1;
   bit     dutCorner = 1'b0;
   int     borderCorners = 0;

   harris_response #(
      .IMG_WIDTH (W),
      .IMG_HEIGHT(H),
      .K_NUM     (KN),
      .K_SHIFT   (KS),
      .THRESH    (52'sd1_000_000_000)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .window      (window),
      .window_valid(window_valid),
      .corner_valid(corner_valid),
      .corner      (corner),
      .response    (response),
      .corner_x    (corner_x),
      .corner_y    (corner_y),
      .frame_done  (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      nVectors++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint pv(input winT w, input int r, input int c);
      return longint'(w[r][c]);
   endfunction

   function automatic longint harrisR(input winT w);
      longint sxx, syy, sxy, ix, iy, det, tr;
      sxx = 0;
      syy = 0;
      sxy = 0;
      for (int r = 1; r <= 4; r++) begin
         for (int c = 1; c <= 4; c++) begin
            ix = pv(w, r-1, c+1) + 2 * pv(w, r, c+1) + pv(w, r+1, c+1)
               - pv(w, r-1, c-1) - 2 * pv(w, r, c-1) - pv(w, r+1, c-1);
            iy = pv(w, r+1, c-1) + 2 * pv(w, r+1, c) + pv(w, r+1, c+1)
               - pv(w, r-1, c-1) - 2 * pv(w, r-1, c) - pv(w, r-1, c+1);
            sxx += ix * ix;
            syy += iy * iy;
            sxy += ix * iy;
         end
      end
      sxx = sxx >>> 4;
      syy = syy >>> 4;
      sxy = sxy >>> 4;
      det = sxx * syy - sxy * sxy;
      tr  = sxx + syy;
      return det - ((KN * tr * tr) >>> KS);
   endfunction

   function automatic winT makeWin(input int kind);
      winT w;
      for (int r = 0; r < 6; r++) begin
         for (int c = 0; c < 6; c++) begin
            case (kind)
               0:       w[r][c] = 8'd100;
               1:       w[r][c] = (c < 3) ? 8'd0 : 8'd255;
               2:       w[r][c] = (r < 3 && c < 3) ? 8'd255 : 8'd0;
               default: w[r][c] = 8'($urandom);
            endcase
         end
      end
      return w;
   endfunction

   task automatic step(input winT w, input bit v);
      expT e;
      @(posedge clk);
      #2;
      window       = w;
      window_valid = v;
      if (v && !reset) begin
         e.resp   = harrisR(w);
         e.x      = tbX;
         e.y      = tbY;
         e.corner = (e.resp > THR) && (tbX <= W - 6);
         e.fd     = (tbX == W - 1) && (tbY == H - 6);
         e.due    = cycle + 7;
         sb.push_back(e);
         if (tbX == W - 1) begin
            tbX = 0;
            tbY = (tbY == H - 6) ? 0 : tbY + 1;
         end else begin
            tbX++;
         end
      end
   endtask

   // Reset held one cycle with a valid window present; that window must vanish too.
   task automatic applyReset(input winT w);
      @(posedge clk);
      #2;
      reset        = 1'b1;
      window       = w;
      window_valid = 1'b1;
      sb.delete();
      tbX        = 0;
      tbY        = 0;
      lastResp   = 0;
      lastCorner = 1'b0;
      lastX      = 0;
      lastY      = 0;
      @(posedge clk);
      #2;
      reset        = 1'b0;
      window_valid = 1'b0;
   endtask

   task automatic singleShot(input winT w, input longint expResp, input bit expCorner,
                             input int expX, input int expY);
      step(w, 1'b1);
      repeat (6) step(w, 1'b0);
      @(negedge clk);
      check("latency_early", corner_valid, 0);
      @(negedge clk);
      check("latency_on", corner_valid, 1);
      check("single_response", response, expResp);
      check("single_corner", corner, expCorner);
      check("single_x", corner_x, expX);
      check("single_y", corner_y, expY);
   endtask

   always @(negedge clk) begin
      expT e;
      if (!reset) begin
         if (corner_valid) begin
            check("result_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("latency", cycle, e.due);
               check("response", response, e.resp);
               check("corner", corner, e.corner);
               check("corner_x", corner_x, e.x);
               check("corner_y", corner_y, e.y);
               check("frame_done", frame_done, e.fd);
               lastResp   = e.resp;
               lastCorner = e.corner;
               lastX      = e.x;
               lastY      = e.y;
            end
            dutX      = int'(corner_x);
            dutY      = int'(corner_y);
            dutCorner = corner;
            if (corner && int'(corner_x) >= W - 5) borderCorners++;
            if (frame_done) begin
               fdCount++;
               fdX = int'(corner_x);
               fdY = int'(corner_y);
            end
         end else begin
            check("hold_response", response, lastResp);
            check("hold_corner", corner, lastCorner);
            check("hold_x", corner_x, lastX);
            check("hold_y", corner_y, lastY);
            check("frame_done_idle", frame_done, 0);
         end
         if (sb.size() > 0) check("not_overdue", sb[0].due >= cycle, 1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, expected end of stimulus");
      $fatal(1, "watchdog expired");
   end

   initial begin
      winT flat, vstep, cblock, w4;
      flat   = makeWin(0);
      vstep  = makeWin(1);
      cblock = makeWin(2);

      reset        = 1'b1;
      window_valid = 1'b0;
      window       = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_valid", corner_valid, 0);
      check("reset_corner", corner, 0);
      check("reset_response", response, 0);
      check("reset_x", corner_x, 0);
      check("reset_y", corner_y, 0);
      check("reset_frame_done", frame_done, 0);
      @(posedge clk);
      #2;
      reset = 1'b0;

      singleShot(flat, 0, 1'b0, 0, 0);
      singleShot(vstep, -64'sd10570626562, 1'b0, 1, 0);
      singleShot(cblock, 64'sd33454292255, 1'b1, 2, 0);

      for (int i = 0; i < 12; i++) step(makeWin(3), (i % 2) == 0);
      repeat (10) step(flat, 1'b0);

      for (int i = 0; i < 3; i++) step(makeWin(3), 1'b1);
      applyReset(makeWin(3));
      w4 = makeWin(3);
      singleShot(w4, harrisR(w4), harrisR(w4) > THR, 0, 0);
      for (int i = 0; i < 5; i++) step(makeWin(3), 1'b1);
      repeat (10) step(flat, 1'b0);

      applyReset(cblock);
      fdCount       = 0;
      borderCorners = 0;
      for (int i = 0; i < W * (H - 5); i++) begin
         if ($urandom_range(3) == 0) step(cblock, 1'b0);
         step(cblock, 1'b1);
      end
      repeat (10) step(flat, 1'b0);
      check("frame_done_count", fdCount, 1);
      check("frame_done_x", fdX, W - 1);
      check("frame_done_y", fdY, H - 6);
      check("border_corners", borderCorners, 0);

      step(cblock, 1'b1);
      repeat (10) step(flat, 1'b0);
      check("wrap_x", dutX, 0);
      check("wrap_y", dutY, 0);
      check("wrap_corner", dutCorner, 1);
      check("drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
      $finish;
   end

endmodule

// File: doc/harris_response.md
# harris_response

Pipelined Harris corner-response stage sitting directly downstream of the 6x6 window generator. For every valid window it does four things: computes 3x3 Sobel gradients at the 16 interior positions, accumulates the structure tensor over those positions, evaluates R = det − k·trace², and thresholds R. Each result is tagged with the window's image coordinates, and border windows are suppressed. The output stream feeds non-maximum suppression and corner output.

## Interface
- IMG_WIDTH, 480: pixels per image row; windows per row.
- IMG_HEIGHT, 480: image rows; window rows per frame = IMG_HEIGHT−5.
- K_NUM, 5: Harris k numerator (0..255).
- K_SHIFT, 7: k = K_NUM / 2^K_SHIFT.
- THRESH, 1_000_000_000: signed 52-bit corner threshold.

- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- window  in  8 x [0:5][0:5]  unsigned pixels; window[r][c], row 0 = oldest line.
- window_valid  in  1  window qualifier; one window per cycle when high.
- corner_valid  out  1  result qualifier.
- corner  out  1  R > THRESH and not border.
- response  out  52 signed  R.
- corner_x  out  9  column of window top-left.
- corner_y  out  9  row of window top-left.
- frame_done  out  1  one-cycle pulse with the last result of a frame.

## Operation
- No backpressure. Every window_valid cycle produces exactly one result. Bubbles propagate unchanged.
- Stage 1 registers the window, valid, x and y.
- Stage 2 computes Sobel gradients at positions r,c ∈ 1..4, giving 11-bit signed results in ±1020:
  - Ix = (p[r−1][c+1] + 2p[r][c+1] + p[r+1][c+1]) − (same terms at c−1).
  - Iy = the same form with rows and columns swapped: row r+1 minus row r−1.
- Stage 3 forms per-position products: Ix², Iy² (21-bit unsigned) and Ix·Iy (22-bit signed).
- Stage 4 sums the 16 products into Sxx, Syy (25-bit) and Sxy (26-bit signed), then shifts each right by 4. The shift is arithmetic (floor) for Sxy.
- Stage 5 computes:
  - det = Sxx·Syy − Sxy².
  - t2 = (Sxx+Syy)².
  - All arithmetic is in 52-bit signed.
- Stage 6 computes:
  - R = det − ((K_NUM·t2) >>> K_SHIFT).
  - corner = (R > THRESH signed) & !border.
- Border: a window with x > IMG_WIDTH−6 spans past the row end, so it is flagged border. For such windows corner = 0 and response is still output.
- Coordinate counters x and y (9-bit) advance on window_valid only:
  - x wraps at IMG_WIDTH−1 to 0, and y increments on that wrap.
  - y wraps at IMG_HEIGHT−6 to 0.
  - The window at x = IMG_WIDTH−1, y = IMG_HEIGHT−6 is flagged last. Its result asserts frame_done together with corner_valid.

## Timing
- Latency is 6 cycles. A window sampled with window_valid at edge n drives corner_valid, corner, response, corner_x, corner_y and frame_done in the cycle following edge n+6.
- Throughput is 1 window/clk. Back-to-back windows give back-to-back results in input order.
- When corner_valid = 0, the data outputs hold their last values.
- Reset values: corner_valid = 0, corner = 0, response = 0, corner_x = 0, corner_y = 0, frame_done = 0. Internal x = y = 0 and all stage valids = 0.
- Reset mid-stream:
  - All in-flight results are dropped, with no corner_valid for them.
  - Counters restart at 0.
  - The first window after reset deasserts is (0,0).
- Reset and window_valid high in the same cycle: reset wins and the window is discarded.
- frame_done is never asserted without corner_valid.

## Test plan
- Flat window, all pixels 100, single valid pulse → after exactly 6 cycles, corner_valid = 1 for one cycle, response = 0, corner = 0, coords (0,0).
- Vertical step, columns 0–2 = 0 and 3–5 = 255 → Sxx = 520200 after the shift, Syy = Sxy = 0; response = −10570626562; corner = 0.
- Top-left 3x3 block 255, rest 0 → Sxx = Syy = 211331, Sxy = 65025; response = 33454292255; corner = 1.
- Corner window from the previous test streamed for a full frame of 480·475 valids with random gaps:
  - coords follow raster order;
  - corner = 0 for every x ≥ 475;
  - frame_done pulses once, with coords (479,474);
  - the next result is (0,0).
- 10 consecutive valid windows of distinct content, then reset asserted at cycle 3 for 1 cycle:
  - no results appear after reset;
  - the next window yields coords (0,0) with correct latency.
- Alternating valid/invalid windows → results at the same 1-0-1 cadence, shifted by 6 cycles; outputs are held during gaps.
